spi_byte_master: RTL and testbench

Byte-oriented SPI master that shifts one 8-bit byte per request, either out on MOSI (send) or in from MISO (receive). It sits between a host-side control FSM and an external SPI slave. It generates SCL from the system clock and manages chip-select automatically: CS stays low across back-to-back requests and releases after a short idle hold.

---
 rtl/spi_byte_master.sv | 75 +++++++
 tb/tb_spi_byte_master.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_master.sv
// spi_byte_master: SPI mode-3, LSB-first byte master with automatic chip-select hold between back-to-back requests.
module spi_byte_master #(
  parameter int CLK_FREC = 100000000,
  parameter int SCL_FREC = 1000000
) (
  input  logic       clk,
  input  logic       arstn,
  input  logic [7:0] byte_send,
  output logic [7:0] byte_receive,
  input  logic       send_byte,
  input  logic       receive_byte,
  output logic       system_idle,
  output logic       new_byte,
  input  logic       miso,
  output logic       mosi,
  output logic       scl,
  output logic       cs
);
  localparam int HALF = CLK_FREC / (2 * SCL_FREC);
  localparam int CW = $clog2(2 * HALF);
  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx, bit_nx;
  logic [7:0] tx, tx_nx, rx_sh;
  logic is_rx, rx_nx, accept, half_done, hold_done, finish;
  assign accept = (state == IDLE || state == HOLD) && (send_byte || receive_byte);
  assign half_done = cnt == CW'(HALF - 1);
  assign hold_done = cnt == CW'(2 * HALF - 1);
  assign finish = state == HIGH && half_done && bit_idx == 3'd7;
  assign tx_nx = accept ? byte_send : tx;
  assign rx_nx = accept ? !send_byte : is_rx;
  assign bit_nx = accept ? 3'd0 : (state == HIGH && state_nx == LOW) ? bit_idx + 3'd1 : bit_idx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? SETUP : IDLE;
      SETUP:   state_nx = half_done ? LOW : SETUP;
      LOW:     state_nx = half_done ? HIGH : LOW;
      HIGH:    state_nx = half_done ? (bit_idx == 3'd7 ? HOLD : LOW) : HIGH;
      HOLD:    state_nx = accept ? LOW : hold_done ? IDLE : HOLD;
      default: state_nx = IDLE;
    endcase
  end
  // Outputs are registered from the next state so scl/cs never glitch on state decode.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      tx <= '0;
      rx_sh <= '0;
      is_rx <= 1'b0;
      byte_receive <= '0;
      new_byte <= 1'b0;
      mosi <= 1'b0;
      scl <= 1'b1;
      cs <= 1'b1;
      system_idle <= 1'b1;
    end else begin
      state <= state_nx;
      cnt <= (state_nx != state || state == IDLE) ? '0 : cnt + CW'(1);
      bit_idx <= bit_nx;
      tx <= tx_nx;
      is_rx <= rx_nx;
      scl <= state_nx != LOW;
      cs <= state_nx == IDLE;
      system_idle <= state_nx == IDLE || state_nx == HOLD;
      new_byte <= finish && is_rx;
      if (state == LOW && half_done) rx_sh[bit_idx] <= miso;
      if (finish && is_rx) byte_receive <= rx_sh;
      if (state_nx == LOW && state != LOW) mosi <= !rx_nx && tx_nx[bit_nx];
    end
  end
endmodule

// File: tb/tb_spi_byte_master.sv
// tb_spi_byte_master: directed plus random transfers checked against an SPI slave model living in the bench.
module tb_spi_byte_master;
  localparam int HALF = 4;
  logic clk = 1'b0, arstn = 1'b0, send_byte = 1'b0, receive_byte = 1'b0, miso = 1'b0;
  logic [7:0] byte_send = 8'h00;
  logic [7:0] byte_receive;
  logic system_idle, new_byte, mosi, scl, cs;
  int errors = 0, checks = 0;
  int rises = 0, falls = 0, nb_cycles = 0, viol = 0, mosi_hi = 0;
  int fall_base = 0, rise_base = 0, nb_base = 0, mosi_base = 0;
  logic [7:0] slave_tx = 8'h00, sniff = 8'h00, exp_rx = 8'h00;
  logic prev_scl = 1'b1;

  spi_byte_master #(.CLK_FREC(8), .SCL_FREC(1)) dut (
    .clk(clk), .arstn(arstn), .byte_send(byte_send), .byte_receive(byte_receive),
    .send_byte(send_byte), .receive_byte(receive_byte), .system_idle(system_idle),
    .new_byte(new_byte), .miso(miso), .mosi(mosi), .scl(scl), .cs(cs)
  );

  always #5 clk = ~clk;

  // Slave: samples mosi on scl rise (LSB first), drives bit i of slave_tx on the i-th scl fall.
  always @(posedge clk) begin
    #1;
    if (scl && !prev_scl) begin
      rises++;
      sniff = {mosi, sniff[7:1]};
      mosi_hi += int'(mosi);
    end
    if (!scl && prev_scl) begin
      miso = slave_tx[3'(falls - fall_base)];
      falls++;
    end
    nb_cycles += int'(new_byte);
    if (cs && !scl) viol++;
    prev_scl = scl;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic request(input logic s, input logic r, input logic [7:0] d);
    int n = 0;
    while (!system_idle && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("req_wait_timeout", n, 0);
    fall_base = falls;
    rise_base = rises;
    nb_base = nb_cycles;
    mosi_base = mosi_hi;
    byte_send = d;
    send_byte = s;
    receive_byte = r;
    @(negedge clk);
    send_byte = 1'b0;
    receive_byte = 1'b0;
  endtask

  task automatic do_xfer(input logic s, input logic r, input logic [7:0] d, input logic [7:0] sl,
                         input bit hold, input bit mid);
    int n = 0;
    slave_tx = sl;
    request(s, r, d);
    check("sys_idle_drop", int'(system_idle), 0);
    check("cs_low", int'(cs), 0);
    if (hold) check("fall_from_hold", int'(scl), 0);
    else begin
      while (scl && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("setup_len", n, HALF);
    end
    if (mid) begin
      repeat (3) @(negedge clk);
      receive_byte = 1'b1;
      @(negedge clk);
      receive_byte = 1'b0;
      n += 4;
    end
    while (!system_idle && n < 40 * HALF) begin
      @(negedge clk);
      n++;
    end
    check("xfer_len", n, hold ? 16 * HALF : 17 * HALF);
    check("scl_rises", rises - rise_base, 8);
    if (s) begin
      check("tx_byte", int'(sniff), int'(d));
      check("tx_no_new_byte", nb_cycles - nb_base, 0);
    end else begin
      exp_rx = sl;
      check("rx_new_byte", nb_cycles - nb_base, 1);
      check("rx_mosi_zero", mosi_hi - mosi_base, 0);
    end
    check("byte_receive", int'(byte_receive), int'(exp_rx));
  endtask

  task automatic idle_release();
    int n = 0;
    int drops = 0;
    while (!cs && n < 40 * HALF) begin
      drops += int'(!system_idle);
      @(negedge clk);
      n++;
    end
    check("cs_release", n, 2 * HALF);
    check("idle_held", drops, 0);
  endtask

  initial begin
    logic [7:0] d;
    int n;
    bit hold;
    int op;
    repeat (10) @(negedge clk);
    check("rst_cs", int'(cs), 1);
    check("rst_scl", int'(scl), 1);
    check("rst_mosi", int'(mosi), 0);
    check("rst_idle", int'(system_idle), 1);
    check("rst_byte_receive", int'(byte_receive), 0);
    check("rst_new_byte", int'(new_byte), 0);
    arstn = 1'b1;
    repeat (3) @(negedge clk);
    do_xfer(1, 0, 8'h01, 8'hFF, 0, 0);
    do_xfer(1, 0, 8'h02, 8'h00, 1, 0);
    do_xfer(1, 0, 8'h03, 8'hAA, 1, 0);
    do_xfer(1, 0, 8'h04, 8'h55, 1, 0);
    do_xfer(0, 1, 8'hFF, 8'h2D, 1, 0);
    do_xfer(0, 1, 8'hFF, 8'h35, 1, 0);
    do_xfer(0, 1, 8'h00, 8'h33, 1, 0);
    do_xfer(0, 1, 8'hFF, 8'h19, 1, 0);
    idle_release();
    do_xfer(1, 0, 8'h0B, 8'h00, 0, 0);
    idle_release();
    do_xfer(1, 1, 8'hA5, 8'h3C, 0, 1);
    idle_release();
    slave_tx = 8'h00;
    request(1, 0, 8'hC3);
    n = 0;
    while (falls - fall_base < 4 && n < 40 * HALF) begin
      @(negedge clk);
      n++;
    end
    check("reach_bit3", falls - fall_base, 4);
    arstn = 1'b0;
    @(negedge clk);
    check("abort_cs", int'(cs), 1);
    check("abort_scl", int'(scl), 1);
    check("abort_idle", int'(system_idle), 1);
    check("abort_mosi", int'(mosi), 0);
    check("abort_new_byte", int'(new_byte), 0);
    check("abort_byte_receive", int'(byte_receive), 0);
    exp_rx = 8'h00;
    arstn = 1'b1;
    @(negedge clk);
    do_xfer(1, 0, 8'h29, 8'h00, 0, 0);
    for (int i = 0; i < 8; i++) begin
      hold = 1'($urandom_range(0, 1));
      if (!hold) idle_release();
      op = int'($urandom_range(0, 2));
      d = 8'($urandom);
      do_xfer(op != 1, op != 0, d, 8'($urandom), hold, 0);
    end
    idle_release();
    check("cs_high_scl_low", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
